alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_mul_seq.sv | 45 ++++
 rtl/alu_multicycle.sv | 119 +++++++++++
 tb/tb_alu_multicycle.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: operation encodings and control states shared by the multicycle ALU
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_AND  = 4'b0001,
    ALU_OR   = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_ADD  = 4'b1000,
    ALU_MUL  = 4'b1001,
    ALU_SUB  = 4'b1100,
    ALU_SLT  = 4'b1101,
    ALU_SLTU = 4'b1111
  } alu_control_t;
  typedef enum logic {S_IDLE, S_MUL} state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add unsigned multiplier, one multiplier bit per cycle, LSB first
module alu_mul_seq #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = $clog2(N);
  logic           r_busy;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_mcand;
  logic [N-1:0]   r_mplier;
  logic [2*N-1:0] w_sum;
  assign w_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);
  // done flags the step that completes the product, so the caller can load it on the same edge
  assign done    = r_busy && (r_cnt == CW'(N - 1));
  assign product = w_sum;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{N{1'b0}}, a};
      r_mplier <= b;
    end else if (r_busy) begin
      r_busy   <= !done;
      r_cnt    <= r_cnt + 1'b1;
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: valid/ready ALU, single-cycle ops plus an N-cycle iterative multiply
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  alu_control_t op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] out,
  output logic         overflow,
  output logic         inputs_equal,
  output logic         outputs_zero
);
  localparam int SW = $clog2(N);
  state_t         r_state;
  state_t         w_next;
  logic           r_valid;
  logic [N-1:0]   r_out;
  logic           r_ovf;
  logic           r_eq;
  logic           r_zero;
  logic           r_mul_eq;
  logic           w_accept;
  logic           w_start;
  logic           w_done;
  logic           w_load_alu;
  logic           w_load_mul;
  logic [2*N-1:0] w_product;
  logic [N-1:0]   w_sum;
  logic [N-1:0]   w_diff;
  logic [SW-1:0]  w_sh;
  logic [N-1:0]   w_res;
  logic           w_ovf;
  assign i_ready    = (r_state == S_IDLE) && (!r_valid || o_ready);
  assign w_accept   = i_valid && i_ready;
  assign w_start    = w_accept && (op == ALU_MUL);
  assign w_load_alu = w_accept && (op != ALU_MUL);
  assign w_load_mul = (r_state == S_MUL) && w_done;
  assign w_sum      = a + b;
  assign w_diff     = a - b;
  assign w_sh       = b[SW-1:0];
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (op)
      ALU_AND:  w_res = a & b;
      ALU_OR:   w_res = a | b;
      ALU_XOR:  w_res = a ^ b;
      ALU_SLL:  w_res = a << w_sh;
      ALU_SRL:  w_res = a >> w_sh;
      ALU_SRA:  w_res = $signed(a) >>> w_sh;
      ALU_ADD: begin
        w_res = w_sum;
        w_ovf = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        w_res = w_diff;
        w_ovf = (a[N-1] != b[N-1]) && (w_diff[N-1] != a[N-1]);
      end
      ALU_SLT:  w_res = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: w_res = {{(N-1){1'b0}}, a < b};
      default:  w_res = '0;
    endcase
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == S_IDLE) ? (w_start ? S_MUL : S_IDLE) : (w_done ? S_IDLE : S_MUL);
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end
  // multiply operands equality is latched at accept since a/b are free to change during the run
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_out    <= '0;
      r_ovf    <= 1'b0;
      r_eq     <= 1'b0;
      r_zero   <= 1'b0;
      r_mul_eq <= 1'b0;
    end else begin
      if (w_load_alu) begin
        r_out  <= w_res;
        r_ovf  <= w_ovf;
        r_eq   <= (a == b);
        r_zero <= (w_res == '0);
      end else if (w_load_mul) begin
        r_out  <= w_product[N-1:0];
        r_ovf  <= |w_product[2*N-1:N];
        r_eq   <= r_mul_eq;
        r_zero <= (w_product[N-1:0] == '0);
      end
      if (w_start) r_mul_eq <= (a == b);
      r_valid <= w_load_alu || w_load_mul || (r_valid && !o_ready);
    end
  end
  alu_mul_seq #(.N(N)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_start),
    .a       (a),
    .b       (b),
    .done    (w_done),
    .product (w_product)
  );
  assign o_valid      = r_valid;
  assign out          = r_out;
  assign overflow     = r_ovf;
  assign inputs_equal = r_eq;
  assign outputs_zero = r_zero;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vector table plus handshake, stall and reset-abort sequences
module tb_alu_multicycle;
  import alu_pkg::*;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_ready;
  alu_control_t op = ALU_ADD;
  logic [31:0]  a = '0;
  logic [31:0]  b = '0;
  logic         o_valid;
  logic         o_ready = 1'b1;
  logic [31:0]  out;
  logic         overflow;
  logic         inputs_equal;
  logic         outputs_zero;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    alu_control_t op;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [31:0]  res;
    logic         ovf;
    logic         eq;
    logic         zero;
  } vec_t;
  vec_t vecs[18];
  always #5 clk = ~clk;
  alu_multicycle #(.N(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_ready      (i_ready),
    .op           (op),
    .a            (a),
    .b            (b),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .out          (out),
    .overflow     (overflow),
    .inputs_equal (inputs_equal),
    .outputs_zero (outputs_zero)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic apply(input int idx, input vec_t v);
    int   waits;
    logic busy_ok;
    string tag;
    tag = $sformatf("vec%0d", idx);
    chk({tag, " i_ready"}, i_ready, 1);
    op = v.op;
    a = v.a;
    b = v.b;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    waits = 0;
    busy_ok = 1'b1;
    while (!o_valid && waits < 100) begin
      if (i_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      waits++;
    end
    chk({tag, " latency"}, waits, (v.op == ALU_MUL) ? 32 : 0);
    chk({tag, " busy"}, busy_ok, 1);
    chk({tag, " o_valid"}, o_valid, 1);
    chk({tag, " out"}, out, v.res);
    chk({tag, " overflow"}, overflow, v.ovf);
    chk({tag, " inputs_equal"}, inputs_equal, v.eq);
    chk({tag, " outputs_zero"}, outputs_zero, v.zero);
    @(negedge clk);
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] held;
    logic        never_valid;
    vec_t        v;
    vecs[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{ALU_SUB,  32'h5,        32'h5,        32'h0,        1'b0, 1'b1, 1'b1};
    vecs[2]  = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{ALU_SLL,  32'h1,        32'd31,       32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{ALU_SLL,  32'h12345678, 32'h0,        32'h12345678, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{ALU_SRL,  32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{ALU_SRA,  32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{ALU_SRA,  32'h40000000, 32'h21,       32'h20000000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{ALU_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1'b0};
    vecs[11] = '{ALU_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b0, 1'b1};
    vecs[12] = '{ALU_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{ALU_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b0, 1'b1};
    vecs[14] = '{alu_control_t'(4'b0000), 32'h3, 32'h3, 32'h0,       1'b0, 1'b1, 1'b1};
    vecs[15] = '{ALU_MUL,  32'h10000,    32'h10000,    32'h0,        1'b1, 1'b1, 1'b1};
    vecs[16] = '{ALU_MUL,  32'd123,      32'd456,      32'd56088,    1'b0, 1'b0, 1'b0};
    vecs[17] = '{ALU_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b1, 1'b1, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset o_valid", o_valid, 0);
    chk("reset out", out, 0);
    chk("reset flags", {overflow, inputs_equal, outputs_zero}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post-reset i_ready", i_ready, 1);
    for (int i = 0; i < 18; i++) apply(i, vecs[i]);
    op = ALU_ADD;
    a = 32'd1;
    b = 32'd1;
    i_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("b2b out%0d", i), out, 2 * i);
      chk($sformatf("b2b valid%0d", i), o_valid, 1);
      a = i + 1;
      b = i + 1;
    end
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b drain o_valid", o_valid, 0);
    @(negedge clk);
    o_ready = 1'b0;
    v = '{ALU_XOR, 32'hA, 32'h5, 32'hF, 1'b0, 1'b0, 1'b0};
    apply(100, v);
    held = out;
    for (int i = 0; i < 5; i++) begin
      op = ALU_ADD;
      a = 32'd1;
      b = 32'd1;
      i_valid = 1'b1;
      chk($sformatf("stall out%0d", i), out, 32'hF);
      chk($sformatf("stall valid%0d", i), o_valid, 1);
      chk($sformatf("stall i_ready%0d", i), i_ready, 0);
      @(negedge clk);
    end
    chk("stall held", held, out);
    o_ready = 1'b1;
    a = 32'd2;
    b = 32'd2;
    #1;
    chk("release i_ready", i_ready, 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    chk("release out", out, 4);
    chk("release valid", o_valid, 1);
    @(negedge clk);
    op = ALU_MUL;
    a = 32'd7;
    b = 32'd9;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    op = ALU_MUL;
    a = 32'd3;
    b = 32'd3;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("abort o_valid", o_valid, 0);
    chk("abort out", out, 0);
    @(negedge clk);
    rst = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("abort i_ready", i_ready, 1);
    never_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (o_valid) never_valid = 1'b0;
    end
    chk("abort no result", never_valid, 1);
    @(negedge clk);
    v = '{ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0};
    apply(101, v);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
